// File: rtl/eth_frame_fifo_if.sv
// Write/read port bundle for eth_frame_fifo.
// Producer/consumer side uses master; the FIFO itself uses slave.
interface eth_frame_fifo_if #(
  parameter int unsigned WIDTH      = 36,
  parameter int unsigned DEPTH_LOG2 = 9
);
  logic                  wr_en_in;
  logic                  wr_chk_in;
  logic                  wr_clr_in;
  logic [WIDTH-1:0]      wr_d_in;
  logic                  wr_full_out;
  logic                  wr_drop_out;
  logic                  rd_en_in;
  logic [WIDTH-1:0]      rd_d_out;
  logic                  rd_valid_out;
  logic                  rd_last_out;
  logic                  rd_empty_out;
  logic [DEPTH_LOG2:0]   rd_frames_out;

  modport master (
    output wr_en_in, wr_chk_in, wr_clr_in, wr_d_in, rd_en_in,
    input  wr_full_out, wr_drop_out, rd_d_out, rd_valid_out,
           rd_last_out, rd_empty_out, rd_frames_out
  );

  modport slave (
    input  wr_en_in, wr_chk_in, wr_clr_in, wr_d_in, rd_en_in,
    output wr_full_out, wr_drop_out, rd_d_out, rd_valid_out,
           rd_last_out, rd_empty_out, rd_frames_out
  );
endinterface

// File: rtl/eth_frame_fifo.sv
// Single-clock Ethernet frame FIFO with speculative write, commit and rollback.
// Only committed frames are readable; overflowed frames are discarded at their commit.
module eth_frame_fifo #(
  parameter int unsigned WIDTH      = 36,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic           clk,
  input  logic           rst,
  eth_frame_fifo_if.slave bus
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned MW    = WIDTH + 1;

  // Storage word: {last, data}
  logic [MW-1:0] mem [DEPTH];

  logic [PW-1:0]    wr_ptr, wr_ptr_nxt;
  logic [PW-1:0]    commit_ptr, commit_ptr_nxt;
  logic [PW-1:0]    rd_ptr, rd_ptr_nxt;
  logic [PW-1:0]    frames, frames_nxt;
  logic             poison, poison_nxt;
  logic             drop, drop_nxt;
  logic [WIDTH-1:0] rd_d, rd_d_nxt;
  logic             rd_last, rd_last_nxt;
  logic             rd_valid, rd_valid_nxt;

  logic             empty_c;
  logic             full_c;
  logic             mem_we_c;
  logic             commit_c;
  logic             pop_c;
  logic             pop_last_c;
  logic [MW-1:0]    rd_word_c;

  // Status flags straight from the registered pointers
  assign empty_c   = (rd_ptr == commit_ptr);
  assign full_c    = ((wr_ptr - rd_ptr) == PW'(DEPTH));
  assign rd_word_c = mem[rd_ptr[AW-1:0]];

  // Next-state for write side, read side and frame count
  always_comb begin
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    rd_ptr_nxt     = rd_ptr;
    frames_nxt     = frames;
    poison_nxt     = poison;
    drop_nxt       = 1'b0;
    rd_d_nxt       = rd_d;
    rd_last_nxt    = rd_last;
    rd_valid_nxt   = 1'b0;
    mem_we_c       = 1'b0;
    commit_c       = 1'b0;
    pop_c          = 1'b0;
    pop_last_c     = 1'b0;

    if (bus.wr_clr_in) begin
      wr_ptr_nxt = commit_ptr;
      poison_nxt = 1'b0;
    end else if (bus.wr_en_in) begin
      if (full_c || poison) begin
        // Overflowed frame: drop words until its commit, then roll back
        if (bus.wr_chk_in) begin
          wr_ptr_nxt = commit_ptr;
          poison_nxt = 1'b0;
          drop_nxt   = 1'b1;
        end else begin
          poison_nxt = 1'b1;
        end
      end else begin
        mem_we_c   = 1'b1;
        wr_ptr_nxt = wr_ptr + PW'(1);
        if (bus.wr_chk_in) begin
          commit_c       = 1'b1;
          commit_ptr_nxt = wr_ptr + PW'(1);
        end
      end
    end

    if (bus.rd_en_in && !empty_c) begin
      pop_c        = 1'b1;
      pop_last_c   = rd_word_c[WIDTH];
      rd_ptr_nxt   = rd_ptr + PW'(1);
      rd_d_nxt     = rd_word_c[WIDTH-1:0];
      rd_last_nxt  = rd_word_c[WIDTH];
      rd_valid_nxt = 1'b1;
    end

    frames_nxt = frames + PW'(commit_c) - PW'(pop_last_c);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      frames     <= '0;
      poison     <= 1'b0;
      drop       <= 1'b0;
      rd_d       <= '0;
      rd_last    <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      frames     <= frames_nxt;
      poison     <= poison_nxt;
      drop       <= drop_nxt;
      rd_d       <= rd_d_nxt;
      rd_last    <= rd_last_nxt;
      rd_valid   <= rd_valid_nxt;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) begin
      mem[wr_ptr[AW-1:0]] <= {bus.wr_chk_in, bus.wr_d_in};
    end
  end

  assign bus.wr_full_out   = full_c;
  assign bus.wr_drop_out   = drop;
  assign bus.rd_d_out      = rd_d;
  assign bus.rd_valid_out  = rd_valid;
  assign bus.rd_last_out   = rd_last;
  assign bus.rd_empty_out  = empty_c;
  assign bus.rd_frames_out = frames;

endmodule

// File: tb/tb_eth_frame_fifo.sv
// Scoreboard bench for eth_frame_fifo (DEPTH_LOG2=4 so overflow is reachable).
// Stimulus pushes expected {last,data}; a negedge monitor pops and compares reads.
module tb_eth_frame_fifo;
  localparam int unsigned WIDTH      = 36;
  localparam int unsigned DEPTH_LOG2 = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   drop_seen = 0;
  logic [WIDTH:0] exp_q[$];

  eth_frame_fifo_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  eth_frame_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Read-side monitor: every valid word must match the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_drop_out) drop_seen++;
      if (bus.rd_valid_out) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected got=%0h last=%0b t=%0t", bus.rd_d_out, bus.rd_last_out, $time);
        end else begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front();
          if ({bus.rd_last_out, bus.rd_d_out} !== e) begin
            bad++;
            $display("FAIL rd_word got=%0b/%0h want=%0b/%0h t=%0t",
                     bus.rd_last_out, bus.rd_d_out, e[WIDTH], e[WIDTH-1:0], $time);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [WIDTH-1:0] d, input bit chk, input bit clr);
    bus.wr_en_in  = 1'b1;
    bus.wr_d_in   = d;
    bus.wr_chk_in = chk;
    bus.wr_clr_in = clr;
    cyc();
    bus.wr_en_in  = 1'b0;
    bus.wr_chk_in = 1'b0;
    bus.wr_clr_in = 1'b0;
  endtask

  task automatic rd(input int n);
    bus.rd_en_in = 1'b1;
    repeat (n) cyc();
    bus.rd_en_in = 1'b0;
  endtask

  task automatic expect_word(input logic [WIDTH-1:0] d, input bit last);
    exp_q.push_back({last, d});
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en_in = 1'b0; bus.wr_chk_in = 1'b0; bus.wr_clr_in = 1'b0;
    bus.wr_d_in = '0;    bus.rd_en_in = 1'b0;
    repeat (2) cyc();
    check("rst_empty",  64'(bus.rd_empty_out), 64'd1);
    check("rst_full",   64'(bus.wr_full_out),  64'd0);
    check("rst_frames", 64'(bus.rd_frames_out), 64'd0);
    check("rst_valid",  64'(bus.rd_valid_out), 64'd0);
    check("rst_d",      64'(bus.rd_d_out),     64'd0);
    rst = 1'b0;
    cyc();

    // 1: ten-word frame, last flag only on final word
    for (int i = 0; i < 10; i++) begin
      wr(WIDTH'(i), i == 9, 1'b0);
      expect_word(WIDTH'(i), i == 9);
      if (i == 8) check("t1_uncommitted_empty", 64'(bus.rd_empty_out), 64'd1);
    end
    check("t1_frames1", 64'(bus.rd_frames_out), 64'd1);
    check("t1_nonempty", 64'(bus.rd_empty_out), 64'd0);
    rd(10);
    check("t1_frames0", 64'(bus.rd_frames_out), 64'd0);
    check("t1_empty", 64'(bus.rd_empty_out), 64'd1);
    cyc();

    // 2: rolled-back frame then a committed one
    for (int i = 20; i < 30; i++) wr(WIDTH'(i), 1'b0, 1'b0);
    wr(WIDTH'(0), 1'b0, 1'b1);
    check("t2_empty", 64'(bus.rd_empty_out), 64'd1);
    check("t2_frames", 64'(bus.rd_frames_out), 64'd0);
    wr(WIDTH'(40), 1'b0, 1'b0); expect_word(WIDTH'(40), 1'b0);
    wr(WIDTH'(41), 1'b0, 1'b0); expect_word(WIDTH'(41), 1'b0);
    wr(WIDTH'(42), 1'b1, 1'b0); expect_word(WIDTH'(42), 1'b1);
    rd(4);
    cyc();
    check("t2_empty_after", 64'(bus.rd_empty_out), 64'd1);

    // 3: uncommitted words are invisible to the reader
    for (int i = 0; i < 5; i++) wr(WIDTH'(100 + i), 1'b0, 1'b0);
    rd(3);
    cyc();
    check("t3_empty", 64'(bus.rd_empty_out), 64'd1);
    check("t3_d_hold", 64'(bus.rd_d_out), 64'd42);
    wr(WIDTH'(0), 1'b0, 1'b1);

    // 4: overflow of a 20-word frame in a 16-word FIFO
    for (int i = 0; i < 20; i++) begin
      wr(WIDTH'(200 + i), i == 19, 1'b0);
      if (i == 14) check("t4_not_full", 64'(bus.wr_full_out), 64'd0);
      if (i == 15) check("t4_full", 64'(bus.wr_full_out), 64'd1);
    end
    check("t4_drop_pulse", 64'(bus.wr_drop_out), 64'd1);
    check("t4_empty", 64'(bus.rd_empty_out), 64'd1);
    cyc();
    check("t4_drop_end", 64'(bus.wr_drop_out), 64'd0);
    check("t4_full_clear", 64'(bus.wr_full_out), 64'd0);
    check("t4_frames", 64'(bus.rd_frames_out), 64'd0);
    wr(WIDTH'(7), 1'b0, 1'b0); expect_word(WIDTH'(7), 1'b0);
    wr(WIDTH'(8), 1'b0, 1'b0); expect_word(WIDTH'(8), 1'b0);
    wr(WIDTH'(9), 1'b1, 1'b0); expect_word(WIDTH'(9), 1'b1);
    rd(3);
    cyc();
    check("t4_empty_after", 64'(bus.rd_empty_out), 64'd1);

    // 5: commit B on the same edge A's last word pops
    wr(WIDTH'('hA0), 1'b0, 1'b0); expect_word(WIDTH'('hA0), 1'b0);
    wr(WIDTH'('hA1), 1'b1, 1'b0); expect_word(WIDTH'('hA1), 1'b1);
    expect_word(WIDTH'('hB0), 1'b0);
    expect_word(WIDTH'('hB1), 1'b0);
    expect_word(WIDTH'('hB2), 1'b1);
    bus.rd_en_in = 1'b1; wr(WIDTH'('hB0), 1'b0, 1'b0);
    bus.rd_en_in = 1'b0; wr(WIDTH'('hB1), 1'b0, 1'b0);
    check("t5_frames_pre", 64'(bus.rd_frames_out), 64'd1);
    bus.rd_en_in = 1'b1; wr(WIDTH'('hB2), 1'b1, 1'b0);
    bus.rd_en_in = 1'b0;
    check("t5_frames_net", 64'(bus.rd_frames_out), 64'd1);
    rd(3);
    check("t5_frames0", 64'(bus.rd_frames_out), 64'd0);
    cyc();

    // 6: reset mid-frame with committed data pending
    wr(WIDTH'(60), 1'b0, 1'b0);
    wr(WIDTH'(61), 1'b1, 1'b0);
    wr(WIDTH'(62), 1'b1, 1'b0);
    wr(WIDTH'(63), 1'b0, 1'b0);
    check("t6_frames2", 64'(bus.rd_frames_out), 64'd2);
    rst = 1'b1;
    exp_q.delete();
    cyc();
    rst = 1'b0;
    check("t6_empty", 64'(bus.rd_empty_out), 64'd1);
    check("t6_full",  64'(bus.wr_full_out),  64'd0);
    check("t6_frames", 64'(bus.rd_frames_out), 64'd0);
    check("t6_valid", 64'(bus.rd_valid_out), 64'd0);
    check("t6_d",     64'(bus.rd_d_out),     64'd0);
    wr(WIDTH'(55), 1'b1, 1'b0); expect_word(WIDTH'(55), 1'b1);
    rd(1);
    cyc();
    cyc();

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("drop_count", 64'(drop_seen), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
